// File: rtl/i2s_tdm_tx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx_pkg
// Shared definitions for the I2S / TDM serial transmitter:
//   I2S_MODE, LJ_MODE : values of the transmitter MODE parameter
//   state_e           : transmitter FSM state type
//   ws_group()        : word-select level carried by a given slot
// ---------------------------------------------------------------------------
package i2s_tdm_tx_pkg;

  // WS leads the first data bit by one bit clock (classic Philips I2S).
  localparam int unsigned I2S_MODE = 0;
  // WS changes together with the first data bit of a slot.
  localparam int unsigned LJ_MODE  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The first half of the slots in a frame form WS group 0, the second half
  // form WS group 1.
  function automatic logic ws_group(input int unsigned slot,
                                    input int unsigned num_ch);
    return (slot >= (num_ch / 2));
  endfunction

endpackage

// File: rtl/i2s_slot_counter.sv
// ---------------------------------------------------------------------------
// i2s_slot_counter
// Bit/slot position tracker for one TDM frame of NUM_CH slots, each
// SLOT_WIDTH bit clocks long. Advances once per bit clock while 'advance'
// is high and wraps to bit 0 / slot 0 after the last bit of the frame.
//
// Ports
//   sclk_i    in   bit clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   advance   in   step to the next bit position
//   bit_idx   out  bit position within the current slot (0..SLOT_WIDTH-1)
//   slot_idx  out  current slot (0..NUM_CH-1)
//   last_bit  out  current bit is the final bit of the frame
//   ws_grp    out  WS group of the current slot
// ---------------------------------------------------------------------------
module i2s_slot_counter
  import i2s_tdm_tx_pkg::*;
#(
  parameter int unsigned SLOT_WIDTH = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned BIT_W      = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1,
  parameter int unsigned SLOT_W     = $clog2(NUM_CH)
) (
  input  logic              sclk_i,
  input  logic              rst_i,
  input  logic              advance,
  output logic [BIT_W-1:0]  bit_idx,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              last_bit,
  output logic              ws_grp
);

  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_CH - 1);

  logic slot_end;

  assign slot_end = (bit_idx == BIT_MAX);
  assign last_bit = slot_end && (slot_idx == SLOT_MAX);
  assign ws_grp   = ws_group(32'(slot_idx), NUM_CH);

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the values from before the edge, independent of the
  // statement order inside the block.
  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_idx  <= '0;
      slot_idx <= '0;
    end else if (advance) begin
      if (slot_end) begin
        bit_idx  <= '0;
        slot_idx <= last_bit ? '0 : slot_idx + SLOT_W'(1);
      end else begin
        bit_idx  <= bit_idx + BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx
// I2S / left-justified TDM serial transmitter with a one-frame holding
// register. Frames of NUM_CH samples (PKT_WIDTH bits each) are accepted
// through a valid/ready handshake and shifted out MSB first, one slot of
// SLOT_WIDTH bits per channel, with zero padding after each sample.
// A frame boundary with nothing to send emits an all-zero frame and
// records an underflow.
//
// Parameters
//   PKT_WIDTH   sample bits per channel
//   SLOT_WIDTH  bit clocks per slot (>= PKT_WIDTH)
//   NUM_CH      channels per frame (2, 4 or 8)
//   MODE        I2S_MODE (WS one bit early) or LJ_MODE (WS aligned)
//
// Ports
//   sclk_i          in   bit clock, all logic on the rising edge
//   rst_i           in   asynchronous active-high reset
//   enable_i        in   run request, sampled at frame boundaries
//   frame_i         in   frame samples, channel 0 in the low PKT_WIDTH bits
//   frameValid_i    in   frame_i valid
//   frameReady_o    out  holding register empty
//   ws_o            out  word select
//   sdata_o         out  serial data
//   underflow_o     out  one-cycle pulse per zero frame inserted
//   underflowCnt_o  out  saturating count of inserted zero frames
// ---------------------------------------------------------------------------
module i2s_tdm_tx
  import i2s_tdm_tx_pkg::*;
#(
  parameter int unsigned PKT_WIDTH  = 16,
  parameter int unsigned SLOT_WIDTH = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned MODE       = I2S_MODE
) (
  input  logic                        sclk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [NUM_CH*PKT_WIDTH-1:0] frame_i,
  input  logic                        frameValid_i,
  output logic                        frameReady_o,
  output logic                        ws_o,
  output logic                        sdata_o,
  output logic                        underflow_o,
  output logic [7:0]                  underflowCnt_o
);

  localparam int unsigned SHIFT_W = NUM_CH * PKT_WIDTH;
  localparam int unsigned BIT_W   = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int unsigned SLOT_W  = $clog2(NUM_CH);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(SLOT_WIDTH - 1);

  state_e              state_q, state_d;
  logic                pending_q;
  logic [SHIFT_W-1:0]  hold_q;
  logic [SHIFT_W-1:0]  shreg_q;

  logic [BIT_W-1:0]    bit_idx;
  logic [SLOT_W-1:0]   slot_idx;
  logic [SLOT_W-1:0]   slot_next;
  logic                last_bit;
  logic                ws_grp;
  logic                ws_next;

  logic                run;
  logic                data_phase;
  logic                accept;
  logic                hold_we;
  logic                load_hold;
  logic                load_bypass;
  logic                load_zero;

  // Reorders a frame so channel 0 sits at the top of the shift register;
  // shifting left then emits channel 0 MSB first, then channel 1, and so on.
  function automatic logic [SHIFT_W-1:0] pack_frame(input logic [SHIFT_W-1:0] f);
    logic [SHIFT_W-1:0] r;
    r = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      r[(NUM_CH-1-n)*PKT_WIDTH +: PKT_WIDTH] = f[n*PKT_WIDTH +: PKT_WIDTH];
    end
    return r;
  endfunction

  i2s_slot_counter #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .NUM_CH     (NUM_CH),
    .BIT_W      (BIT_W),
    .SLOT_W     (SLOT_W)
  ) u_slot_counter (
    .sclk_i   (sclk_i),
    .rst_i    (rst_i),
    .advance  (run),
    .bit_idx  (bit_idx),
    .slot_idx (slot_idx),
    .last_bit (last_bit),
    .ws_grp   (ws_grp)
  );

  assign run = (state_q == ST_RUN);

  // Ready is held low while reset is asserted and rises as soon as it lifts.
  assign frameReady_o = !pending_q && !rst_i;
  assign accept       = frameValid_i && frameReady_o;
  // A frame taken straight into the shift register never occupies the
  // holding register.
  assign hold_we      = accept && !load_bypass;

  // Sample bits occupy the first PKT_WIDTH bit clocks of a slot; the rest
  // of the slot is zero padding and the shift register waits.
  assign data_phase = ({1'b0, bit_idx} < (BIT_W + 1)'(PKT_WIDTH));

  // WS group of the following bit clock, wrapping to frame bit 0.
  assign slot_next = (bit_idx == BIT_MAX) ? slot_idx + SLOT_W'(1) : slot_idx;
  assign ws_next   = last_bit ? ws_group(0, NUM_CH)
                              : ws_group(32'(slot_next), NUM_CH);

  assign sdata_o = run && data_phase && shreg_q[SHIFT_W-1];

  always_comb begin
    ws_o = 1'b0;
    if (run) begin
      ws_o = (MODE == LJ_MODE) ? ws_grp : ws_next;
    end
  end

  // NOTE: every signal driven here gets its default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    load_hold   = 1'b0;
    load_bypass = 1'b0;
    load_zero   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && pending_q) begin
          state_d   = ST_RUN;
          load_hold = 1'b1;
        end
      end
      ST_RUN: begin
        // Frames are only ever switched on their last bit, so dropping
        // enable_i lets the current frame finish before returning to idle.
        if (last_bit) begin
          if (!enable_i) begin
            state_d = ST_IDLE;
          end else if (pending_q) begin
            load_hold = 1'b1;
          end else if (accept) begin
            load_bypass = 1'b1;
          end else begin
            load_zero = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      shreg_q        <= '0;
      underflow_o    <= 1'b0;
      underflowCnt_o <= '0;
    end else begin
      state_q     <= state_d;
      underflow_o <= load_zero;

      if (load_zero && (underflowCnt_o != 8'hFF)) begin
        underflowCnt_o <= underflowCnt_o + 8'd1;
      end

      // load_hold requires pending_q, which blocks a handshake in the same
      // cycle, so the two branches never compete.
      if (hold_we) begin
        pending_q <= 1'b1;
      end else if (load_hold) begin
        pending_q <= 1'b0;
      end

      if (load_hold) begin
        shreg_q <= pack_frame(hold_q);
      end else if (load_bypass) begin
        shreg_q <= pack_frame(frame_i);
      end else if (load_zero) begin
        shreg_q <= '0;
      end else if (run && data_phase) begin
        shreg_q <= {shreg_q[SHIFT_W-2:0], 1'b0};
      end
    end
  end

  // NOTE: the holding register is payload only and is not reset; pending_q
  // (which is reset) decides whether its contents are ever used.
  always_ff @(posedge sclk_i) begin
    if (hold_we) begin
      hold_q <= frame_i;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tdm_tx
// Self-checking bench for i2s_tdm_tx. Three instances share clock and reset:
//   u_d0 : defaults (2 x 16-bit, I2S mode)
//   u_d1 : defaults with left-justified mode
//   u_d2 : 4 channels, 24-bit samples in 32-bit slots, left-justified mode
// Single frames are played from a table of hand-computed bit streams; the
// back-to-back, underflow/saturation and mid-frame reset cases are written
// out as sequences. Inputs change and outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_i2s_tdm_tx;
  import i2s_tdm_tx_pkg::*;

  logic sclk = 1'b0;
  logic rst  = 1'b1;

  always #5 sclk = ~sclk;

  logic        en0, fv0, fr0, ws0, sd0, uf0;
  logic [31:0] frame0;
  logic [7:0]  cnt0;
  logic        en1, fv1, fr1, ws1, sd1, uf1;
  logic [31:0] frame1;
  logic [7:0]  cnt1;
  logic        en2, fv2, fr2, ws2, sd2, uf2;
  logic [95:0] frame2;
  logic [7:0]  cnt2;

  i2s_tdm_tx u_d0 (
    .sclk_i (sclk), .rst_i (rst), .enable_i (en0), .frame_i (frame0),
    .frameValid_i (fv0), .frameReady_o (fr0), .ws_o (ws0), .sdata_o (sd0),
    .underflow_o (uf0), .underflowCnt_o (cnt0)
  );

  i2s_tdm_tx #(.MODE(LJ_MODE)) u_d1 (
    .sclk_i (sclk), .rst_i (rst), .enable_i (en1), .frame_i (frame1),
    .frameValid_i (fv1), .frameReady_o (fr1), .ws_o (ws1), .sdata_o (sd1),
    .underflow_o (uf1), .underflowCnt_o (cnt1)
  );

  i2s_tdm_tx #(.PKT_WIDTH(24), .SLOT_WIDTH(32), .NUM_CH(4), .MODE(LJ_MODE)) u_d2 (
    .sclk_i (sclk), .rst_i (rst), .enable_i (en2), .frame_i (frame2),
    .frameValid_i (fv2), .frameReady_o (fr2), .ws_o (ws2), .sdata_o (sd2),
    .underflow_o (uf2), .underflowCnt_o (cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    bit          sel;     // 0 -> u_d0 (I2S), 1 -> u_d1 (left-justified)
    logic [31:0] frame;
    logic [31:0] exp_sd;  // first serial bit in bit 31
    logic [31:0] exp_ws;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic en, input logic fv,
                       input logic [31:0] f);
    if (sel) begin
      en1 = en; fv1 = fv; frame1 = f;
    end else begin
      en0 = en; fv0 = fv; frame0 = f;
    end
  endtask

  // Hands one frame over while idle, enables for exactly that frame and
  // records 32 bit clocks of sdata/ws starting at the first RUN cycle.
  task automatic play32(input bit sel, input logic [31:0] f,
                        output logic [31:0] sd_s, output logic [31:0] ws_s,
                        output logic uf_seen);
    uf_seen = 1'b0;
    drive(sel, 1'b0, 1'b1, f);
    tick();
    drive(sel, 1'b1, 1'b0, f);
    tick();
    for (int k = 0; k < 32; k++) begin
      sd_s[31-k] = sel ? sd1 : sd0;
      ws_s[31-k] = sel ? ws1 : ws0;
      if ((sel ? uf1 : uf0) === 1'b1) uf_seen = 1'b1;
      if (k == 0) drive(sel, 1'b0, 1'b0, f);
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en0 = 1'b0; fv0 = 1'b0;
    en1 = 1'b0; fv1 = 1'b0;
    en2 = 1'b0; fv2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]  sd_s, ws_s;
    logic         uf_seen;
    logic [127:0] s128, w128;
    logic [63:0]  s64;
    logic [31:0]  bb [6];
    int           idx, rdy_hi, n_pulse, first_k;
    logic         rdy_prev, zero_bad, act, uf_any;
    logic [7:0]   cnt_at;

    vecs[0] = '{"i2s_0aaa_0bbb", 1'b0, 32'h0BBB_0AAA, 32'h0AAA_0BBB, 32'h0001_FFFE};
    vecs[1] = '{"lj_0aaa_0bbb",  1'b1, 32'h0BBB_0AAA, 32'h0AAA_0BBB, 32'h0000_FFFF};
    vecs[2] = '{"i2s_ffff_8001", 1'b0, 32'h8001_FFFF, 32'hFFFF_8001, 32'h0001_FFFE};
    vecs[3] = '{"i2s_last_bit",  1'b0, 32'h0001_0000, 32'h0000_0001, 32'h0001_FFFE};
    vecs[4] = '{"lj_5678_1234",  1'b1, 32'h1234_5678, 32'h5678_1234, 32'h0000_FFFF};

    en0 = 1'b0; fv0 = 1'b0; frame0 = '0;
    en1 = 1'b0; fv1 = 1'b0; frame1 = '0;
    en2 = 1'b0; fv2 = 1'b0; frame2 = '0;
    rst = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    check("rst_ready", 128'({fr0, fr1, fr2}), 128'(0));
    check("rst_ws_sd", 128'({ws0, sd0, ws2, sd2}), 128'(0));
    check("rst_underflow", 128'({uf0, cnt0}), 128'(0));
    rst = 1'b0;
    #1;
    check("ready_after_rst", 128'({fr0, fr1, fr2}), 128'(3'b111));
    tick();

    // ---- single frames from the table ----
    for (int v = 0; v < 5; v++) begin
      play32(vecs[v].sel, vecs[v].frame, sd_s, ws_s, uf_seen);
      check({vecs[v].name, "_sdata"}, 128'(sd_s), 128'(vecs[v].exp_sd));
      check({vecs[v].name, "_ws"}, 128'(ws_s), 128'(vecs[v].exp_ws));
      check({vecs[v].name, "_idle_after"},
            128'({vecs[v].sel ? {ws1, sd1} : {ws0, sd0}, uf_seen}), 128'(0));
    end
    check("table_uf_cnt", 128'({cnt0, cnt1}), 128'(0));

    // ---- 4-channel, 24-in-32 frame ----
    frame2 = {24'h800000, 24'h000001, 24'hABCDEF, 24'h123456};
    fv2 = 1'b1;
    tick();
    fv2 = 1'b0;
    en2 = 1'b1;
    tick();
    uf_any = 1'b0;
    for (int k = 0; k < 128; k++) begin
      s128[127-k] = sd2;
      w128[127-k] = ws2;
      if (uf2 === 1'b1) uf_any = 1'b1;
      if (k == 0) en2 = 1'b0;
      tick();
    end
    check("tdm4_sdata", s128, 128'h12345600_ABCDEF00_00000100_80000000);
    check("tdm4_ws", w128, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF);
    check("tdm4_idle_after", 128'({ws2, sd2, uf_any, cnt2}), 128'(0));

    // ---- back-to-back frames, frameValid_i held high ----
    bb[0] = 32'h2222_1111; bb[1] = 32'h4444_3333; bb[2] = 32'h6666_5555;
    bb[3] = 32'h8888_7777; bb[4] = 32'hAAAA_9999; bb[5] = 32'hCCCC_BBBB;
    idx = 0;
    en0 = 1'b1; fv0 = 1'b1; frame0 = bb[0];
    rdy_prev = fr0;
    tick();
    if (rdy_prev) begin idx = 1; frame0 = bb[1]; end
    rdy_prev = fr0;
    tick();
    rdy_hi = 0;
    uf_any = 1'b0;
    for (int k = 0; k < 128; k++) begin
      if (rdy_prev && idx < 5) begin idx++; frame0 = bb[idx]; end
      s128[127-k] = sd0;
      if (fr0 === 1'b1) rdy_hi++;
      if (uf0 === 1'b1) uf_any = 1'b1;
      rdy_prev = fr0;
      if (k == 100) en0 = 1'b0;
      tick();
    end
    fv0 = 1'b0;
    check("b2b_sdata", s128, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    check("b2b_ready_cycles", 128'(rdy_hi), 128'(4));
    check("b2b_no_underflow", 128'({uf_any, cnt0}), 128'(0));
    check("b2b_idle_after", 128'({ws0, sd0}), 128'(0));

    do_reset();

    // ---- supply stops after two frames: zero frames and underflow ----
    en0 = 1'b1; fv0 = 1'b1; frame0 = 32'h5555_3333;
    tick();
    frame0 = 32'h0F0F_F0F0;
    tick();
    zero_bad = 1'b0;
    n_pulse  = 0;
    first_k  = -1;
    cnt_at   = '0;
    for (int k = 0; k <= 128; k++) begin
      if (k < 64) s64[63-k] = sd0;
      else if (sd0 !== 1'b0) zero_bad = 1'b1;
      if (uf0 === 1'b1) begin
        n_pulse++;
        if (first_k < 0) first_k = k;
      end
      if (k == 1) fv0 = 1'b0;
      if (k == 128) cnt_at = cnt0;
      else tick();
    end
    check("uf_data_frames", 128'(s64), 128'(64'h3333_5555_F0F0_0F0F));
    check("uf_zero_frames", 128'(zero_bad), 128'(0));
    check("uf_pulse_count_3", 128'(n_pulse), 128'(3));
    check("uf_first_pulse_cycle", 128'(first_k), 128'(64));
    check("uf_cnt_after_3", 128'(cnt_at), 128'(3));

    for (int c = 1; c <= 300 * 32; c++) begin
      tick();
      if (uf0 === 1'b1) begin
        n_pulse++;
        if (n_pulse >= 254 && n_pulse <= 256)
          check($sformatf("uf_cnt_at_%0d", n_pulse), 128'(cnt0),
                128'((n_pulse > 255) ? 255 : n_pulse));
      end
    end
    check("uf_pulse_count_303", 128'(n_pulse), 128'(303));
    check("uf_cnt_saturated", 128'(cnt0), 128'(255));

    // ---- reset mid-slot 1 with a frame pending ----
    rst = 1'b1;
    #1;
    check("rst_clears_cnt", 128'({uf0, cnt0}), 128'(0));
    tick();
    rst = 1'b0;
    en0 = 1'b1; fv0 = 1'b1; frame0 = 32'hFFFF_0000;
    tick();
    frame0 = 32'h1357_2468;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (k == 1) fv0 = 1'b0;
      tick();
    end
    check("pre_rst_slot1_active", 128'({ws0, sd0}), 128'(2'b11));
    check("pre_rst_pending", 128'(fr0), 128'(0));
    rst = 1'b1;
    #1;
    check("rst_abort_ws_sd", 128'({ws0, sd0}), 128'(0));
    check("rst_abort_ready_low", 128'(fr0), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_midframe_rst", 128'(fr0), 128'(1));
    tick();
    act = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ((ws0 | sd0 | uf0 | ~fr0) !== 1'b0) act = 1'b1;
      tick();
    end
    check("idle_until_new_frame", 128'({act, cnt0}), 128'(0));
    en0 = 1'b0;
    play32(1'b0, 32'h0001_8000, sd_s, ws_s, uf_seen);
    check("post_rst_frame_sdata", 128'(sd_s), 128'(32'h8000_0001));
    check("post_rst_frame_ws", 128'({ws_s, uf_seen}), 128'({32'h0001_FFFE, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_tx.md
I2S_TDM_TX -- requirements
Module: i2s_tdm_tx

Interface
REQ-001 SHALL have parameter PKT_WIDTH, default 16, sample bits per channel.
REQ-002 SHALL have parameter SLOT_WIDTH, default 16, bits per slot (SLOT_WIDTH >= PKT_WIDTH).
REQ-003 SHALL have parameter NUM_CH, default 2, channels per frame (2, 4 or 8).
REQ-004 SHALL have parameter MODE, default 0, where 0 = I2S (one-bit WS lead) and 1 = left-justified.
REQ-005 SHALL have port sclk_i  in  1  bit clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable_i  in  1  run request.
REQ-008 SHALL have port frame_i  in  NUM_CH*PKT_WIDTH  frame samples; channel 0 in the least-significant PKT_WIDTH bits.
REQ-009 SHALL have port frameValid_i  in  1  frame_i valid.
REQ-010 SHALL have port frameReady_o  out  1  holding register empty.
REQ-011 SHALL have port ws_o  out  1  word select.
REQ-012 SHALL have port sdata_o  out  1  serial data.
REQ-013 SHALL have port underflow_o  out  1  one-cycle underflow pulse.
REQ-014 SHALL have port underflowCnt_o  out  8  saturating underflow count.

Function
REQ-015 SHALL contain a one-frame holding register; a frame is accepted on a rising edge with frameValid_i && frameReady_o, and frameReady_o = !pending (combinational).
REQ-016 SHALL implement states IDLE and RUN.
REQ-017 In IDLE, ws_o and sdata_o SHALL be 0, and the block SHALL move to RUN when enable_i && pending.
REQ-018 On entry to RUN, the pending frame SHALL load into the shift register and pending SHALL clear; bit 0 of the frame SHALL appear on sdata_o in the first RUN cycle.
REQ-019 A frame SHALL be NUM_CH slots x SLOT_WIDTH bits; slot n SHALL carry channel n, MSB first, followed by SLOT_WIDTH-PKT_WIDTH zeros.
REQ-020 The bit counter SHALL count 0..SLOT_WIDTH-1 and the slot counter 0..NUM_CH-1, both wrapping at the frame end.
REQ-021 The WS group of slot s SHALL be 0 for s < NUM_CH/2, else 1.
REQ-022 In MODE 1, ws_o SHALL equal the group of the current bit; in MODE 0, ws_o SHALL equal the group of the next bit, wrapping to frame bit 0.
REQ-023 On the last bit of a frame with enable_i=1: if pending, load the pending frame; else if a handshake occurs in that same cycle, load frame_i directly (bypass, pending stays 0); else load all zeros, pulse underflow_o, and increment underflowCnt_o, saturating at 255.
REQ-024 If enable_i=0 on the last bit of a frame, the block SHALL go to IDLE; enable_i SHALL never truncate a frame in progress.
REQ-025 A handshake SHALL be accepted in any state whenever pending=0.
REQ-026 Underflow SHALL NOT occur in IDLE.

Reset
REQ-027 While rst_i is asserted: state=IDLE; ws_o=0; sdata_o=0; pending=0; frameReady_o=0; underflow_o=0; underflowCnt_o=0; counters=0.
REQ-028 A mid-frame reset SHALL abort immediately and discard both the pending and the shifting frame.
REQ-029 frameReady_o SHALL go to 1 on the first cycle after rst_i deasserts.

Structure
REQ-030 A shared package SHALL hold the mode constants (I2S_MODE=0, LJ_MODE=1) and the state enum type.
REQ-031 The bit/slot counter SHALL be one sub-module, i2s_slot_counter, which outputs bit index, slot index, last-bit flag and WS group; the shift register and FSM SHALL be in the top module.

Verification
REQ-032 Defaults, enable_i=1, one frame {R=16'h0BBB, L=16'h0AAA}: sdata_o SHALL carry 0AAA then 0BBB MSB first; ws_o SHALL rise on the cycle carrying L bit 0 and fall on R bit 0.
REQ-033 MODE=1, same frame: ws_o SHALL rise coincident with the R MSB.
REQ-034 NUM_CH=4, SLOT_WIDTH=32, PKT_WIDTH=24, samples 24'h123456, 24'hABCDEF, 24'h000001, 24'h800000: each slot SHALL carry 24 data bits plus 8 zeros; ws_o SHALL be low for slots 0-1 and high for slots 2-3.
REQ-035 Back-to-back frames with frameValid_i held high: no underflow; frameReady_o SHALL toggle once per frame; output SHALL be continuous.
REQ-036 Frame supply stopped after 2 frames while enable_i=1: zero frames SHALL be sent; underflow_o SHALL pulse at each frame boundary; underflowCnt_o=3 after 3 boundaries; then 300 boundaries -> underflowCnt_o=255.
REQ-037 rst_i pulsed mid-slot 1 with a frame pending: ws_o and sdata_o SHALL be 0 immediately; after release, frameReady_o=1 and the block SHALL be in IDLE until a new frame arrives.
